// File: rtl/fpcvt_normalize.sv
// Front stage of the 12-bit two's-complement to 8-bit float converter.
// Takes |D|, finds the leading one serially and emits S, sign_rep, E and F.
module fpcvt_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] D,
    output logic        out_valid,
    output logic        S,
    output logic [11:0] sign_rep,
    output logic [2:0]  E,
    output logic [3:0]  F
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_sign;
    logic        r_special;
    logic [11:0] r_mag;
    logic [11:0] r_work;
    logic [2:0]  r_ecnt;
    logic        r_s;
    logic [11:0] r_sign_rep;
    logic [2:0]  r_e;
    logic [3:0]  r_f;

    // Two's-complement magnitude; 0x800 wraps back onto itself.
    logic [11:0] w_mag;
    assign w_mag = D[11] ? (~D + 12'd1) : D;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of one another regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_special   <= 1'b0;
            r_mag       <= '0;
            r_work      <= '0;
            r_ecnt      <= '0;
            r_s         <= 1'b0;
            r_sign_rep  <= '0;
            r_e         <= '0;
            r_f         <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign     <= D[11];
                        r_mag      <= w_mag;
                        r_work     <= {w_mag[10:0], 1'b0};
                        r_ecnt     <= 3'd7;
                        r_special  <= (D == 12'h800);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_special) begin
                        r_s         <= r_sign;
                        r_e         <= 3'd7;
                        r_f         <= 4'b1111;
                        r_sign_rep  <= 12'h800;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_work[11] || (r_ecnt == 3'd0)) begin
                        r_s         <= r_sign;
                        r_e         <= r_ecnt;
                        r_f         <= r_work[11:8];
                        r_sign_rep  <= r_mag;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_work <= {r_work[10:0], 1'b0};
                        r_ecnt <= r_ecnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign sign_rep  = r_sign_rep;
    assign E         = r_e;
    assign F         = r_f;

endmodule

// File: tb/tb_fpcvt_normalize.sv
// Self-checking bench for fpcvt_normalize: directed cases, a reset abort,
// and a shuffled sweep of all 4096 inputs against an arithmetic model.
module tb_fpcvt_normalize;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        S;
    logic [11:0] sign_rep;
    logic [2:0]  E;
    logic [3:0]  F;

    int n_tests = 0;
    int n_fail  = 0;

    fpcvt_normalize dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .D        (D),
        .out_valid(out_valid),
        .S        (S),
        .sign_rep (sign_rep),
        .E        (E),
        .F        (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: leading-zero count of |D| mapped straight to E/F, plus the
    // edge count from accept to the edge where a consumer samples out_valid.
    task automatic ref_model(input logic [11:0] d, output logic s, output logic [11:0] rep,
                             output logic [2:0] e, output logic [3:0] f, output int lat);
        int mag;
        int lz;
        int k;
        s   = d[11];
        mag = d[11] ? ((4096 - int'(d)) % 4096) : int'(d);
        rep = 12'(mag);
        lz  = 12;
        for (int b = 11; b >= 0; b--) begin
            if ((mag >> b) & 1) begin
                lz = 11 - b;
                break;
            end
        end
        if (d == 12'h800) begin
            e = 3'd7;
            f = 4'hF;
            k = 0;
        end else if (lz <= 7) begin
            e = 3'(8 - lz);
            f = 4'((mag >> (8 - lz)) & 15);
            k = lz - 1;
        end else begin
            e = 3'd0;
            f = 4'(mag & 15);
            k = 7;
        end
        lat = k + 2;
    endtask

    // Called #1 after a posedge. Waits for in_ready, presents d, then follows
    // the sample to completion. With keep_valid the valid line stays high and
    // D carries junk, which must be ignored while busy.
    task automatic run_sample(input logic [11:0] d, input bit keep_valid, input string tag);
        logic        es;
        logic [11:0] erep;
        logic [2:0]  ee;
        logic [3:0]  ef;
        int          elat;
        int          wait_cnt;
        int          j;
        int          pulses;
        bit          busy_ok;
        bit          done;
        ref_model(d, es, erep, ee, ef, elat);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        if (!in_ready) check({tag, " ready_timeout"}, 32'(in_ready), 32'd1);
        D        = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        D = ~d;
        if (!keep_valid) in_valid = 1'b0;
        j       = 0;
        pulses  = 0;
        busy_ok = 1'b1;
        done    = 1'b0;
        while (!done && j < 20) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            j++;
            if (out_valid) begin
                done = 1'b1;
                pulses++;
            end
        end
        check({tag, " timeout"}, 32'(done), 32'd1);
        check({tag, " busy_in_ready"}, 32'(busy_ok), 32'd1);
        check({tag, " latency"}, 32'(j + 1), 32'(elat));
        check({tag, " S"}, 32'(S), 32'(es));
        check({tag, " sign_rep"}, 32'(sign_rep), 32'(erep));
        check({tag, " E"}, 32'(E), 32'(ee));
        check({tag, " F"}, 32'(F), 32'(ef));
        @(posedge clk);
        #1;
        if (out_valid) pulses++;
        check({tag, " pulses"}, 32'(pulses), 32'd1);
        check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, " hold_E"}, 32'(E), 32'(ee));
        check({tag, " hold_F"}, 32'(F), 32'(ef));
    endtask

    initial begin
        int perm [4096];
        bit saw_pulse;

        rst      = 1'b1;
        in_valid = 1'b0;
        D        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset outputs", {15'd0, S, sign_rep, E, F}, 32'd0);

        run_sample(12'h07D, 1'b0, "d07d");
        run_sample(12'hF6A, 1'b0, "df6a");
        run_sample(12'h7FF, 1'b0, "d7ff");
        run_sample(12'h800, 1'b0, "d800");
        run_sample(12'h000, 1'b1, "b2b_000");
        run_sample(12'hFFF, 1'b0, "b2b_fff");

        // Abort: reset lands on the third SHIFT edge of a long search.
        D        = 12'h003;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        saw_pulse = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_pulse = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort outputs", {15'd0, S, sign_rep, E, F}, 32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_pulse = 1'b1;
        end
        check("abort no_out_valid", 32'(saw_pulse), 32'd0);
        run_sample(12'h100, 1'b0, "after_abort_100");

        for (int i = 0; i < 4096; i++) perm[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int r;
            int t;
            r       = int'($urandom_range(i, 0));
            t       = perm[i];
            perm[i] = perm[r];
            perm[r] = t;
        end
        for (int i = 0; i < 4096; i++) begin
            run_sample(12'(perm[i]), 1'b0, $sformatf("sweep_%03h", perm[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
